// File: rtl/fifo64_split_feeder.sv
// rtl/fifo64_split_feeder.sv - splits a wide sample stream into up/down half-word handshakes and counts an acquisition
// Optional stall watchdog enabled with FIFO64_SPLIT_STALL_WATCHDOG_EN.
module fifo64_split_feeder #(
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                reset_op,
    input  logic [CNT_W-1:0]    n_samples,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic                up_valid,
    output logic [DATA_W/2-1:0] up_data,
    input  logic                up_ready,
    output logic                down_valid,
    output logic [DATA_W/2-1:0] down_data,
    input  logic                down_ready,
    output logic [DATA_W/2-1:0] result_up,
    output logic [DATA_W/2-1:0] result_down,
    output logic [CNT_W-1:0]    sample_count,
    output logic                finalizacion
`ifdef FIFO64_SPLIT_STALL_WATCHDOG_EN
    ,
    output logic                stall_err
`endif
);

    localparam int HW = DATA_W / 2;

    if ((DATA_W % 2) != 0 || STALL_LIMIT < 1) begin : g_param_check
        $error("fifo64_split_feeder: DATA_W must be even and STALL_LIMIT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             up_vld_q, up_vld_d;
    logic             dn_vld_q, dn_vld_d;
    logic [HW-1:0]    up_data_q, up_data_d;
    logic [HW-1:0]    dn_data_q, dn_data_d;
    logic [HW-1:0]    res_up_q, res_up_d;
    logic [HW-1:0]    res_dn_q, res_dn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic up_xfer, dn_xfer, accept;

    assign up_xfer  = up_vld_q && up_ready;
    assign dn_xfer  = dn_vld_q && down_ready;
    // A slot counts as free if it is empty or emptying this cycle, giving one sample per cycle.
    assign in_ready = (state_q == RUN) && (!up_vld_q || up_ready) && (!dn_vld_q || down_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        up_vld_d  = up_vld_q;
        dn_vld_d  = dn_vld_q;
        up_data_d = up_data_q;
        dn_data_d = dn_data_q;
        res_up_d  = res_up_q;
        res_dn_d  = res_dn_q;
        cnt_d     = cnt_q;

        if (up_xfer) begin
            up_vld_d = 1'b0;
            res_up_d = up_data_q;
        end
        if (dn_xfer) begin
            dn_vld_d = 1'b0;
            res_dn_d = dn_data_q;
        end
        if (accept) begin
            up_vld_d  = 1'b1;
            dn_vld_d  = 1'b1;
            up_data_d = in_data[DATA_W-1:HW];
            dn_data_d = in_data[HW-1:0];
            cnt_d     = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                // >= so a limit lowered below the current count still ends on the next accept.
                if (accept && (n_samples != '0) && (cnt_d >= n_samples)) state_d = DRAIN;
                else if (!enable)                                         state_d = IDLE;
            end
            DRAIN: begin
                if (!up_vld_d && !dn_vld_d) state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            up_vld_q  <= 1'b0;
            dn_vld_q  <= 1'b0;
            up_data_q <= '0;
            dn_data_q <= '0;
            res_up_q  <= '0;
            res_dn_q  <= '0;
            cnt_q     <= '0;
        end else if (reset_op) begin
            // Export registers survive an operation clear.
            state_q   <= IDLE;
            up_vld_q  <= 1'b0;
            dn_vld_q  <= 1'b0;
            up_data_q <= '0;
            dn_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            up_vld_q  <= up_vld_d;
            dn_vld_q  <= dn_vld_d;
            up_data_q <= up_data_d;
            dn_data_q <= dn_data_d;
            res_up_q  <= res_up_d;
            res_dn_q  <= res_dn_d;
            cnt_q     <= cnt_d;
        end
    end

    assign up_valid     = up_vld_q;
    assign up_data      = up_data_q;
    assign down_valid   = dn_vld_q;
    assign down_data    = dn_data_q;
    assign result_up    = res_up_q;
    assign result_down  = res_dn_q;
    assign sample_count = cnt_q;
    assign finalizacion = (state_q == DONE);

`ifdef FIFO64_SPLIT_STALL_WATCHDOG_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          stall_err_q, stall_err_d;
    logic          stalled;

    assign stalled = (up_vld_q && !up_ready) || (dn_vld_q && !down_ready);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;
        if (up_xfer || dn_xfer)
            stall_cnt_d = '0;
        else if (stalled && (stall_cnt_q != SW'(STALL_LIMIT)))
            stall_cnt_d = stall_cnt_q + SW'(1);
        if (stall_cnt_d == SW'(STALL_LIMIT))
            stall_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || reset_op) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err = stall_err_q;
`endif

endmodule

// File: tb/tb_fifo64_split_feeder.sv
// tb/tb_fifo64_split_feeder.sv - directed self-checking bench for fifo64_split_feeder
module tb_fifo64_split_feeder;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;
    localparam int HW     = DATA_W / 2;

    logic              clk = 1'b0;
    logic              reset_n, enable, reset_op;
    logic [CNT_W-1:0]  n_samples;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              up_valid, up_ready, down_valid, down_ready;
    logic [HW-1:0]     up_data, down_data, result_up, result_down;
    logic [CNT_W-1:0]  sample_count;
    logic              finalizacion;
`ifdef FIFO64_SPLIT_STALL_WATCHDOG_EN
    logic              stall_err;
`endif

    int total = 0;
    int bad   = 0;

    fifo64_split_feeder #(.DATA_W(DATA_W), .CNT_W(CNT_W), .STALL_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .reset_op(reset_op),
        .n_samples(n_samples), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
        .down_valid(down_valid), .down_data(down_data), .down_ready(down_ready),
        .result_up(result_up), .result_down(result_down),
        .sample_count(sample_count), .finalizacion(finalizacion)
`ifdef FIFO64_SPLIT_STALL_WATCHDOG_EN
        , .stall_err(stall_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [63:0] samples [4] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                                 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
    logic [31:0] up_exp  [4] = '{32'h1111_2222, 32'h5555_6666, 32'h9999_AAAA, 32'hDDDD_EEEE};
    logic [31:0] dn_exp  [4] = '{32'h3333_4444, 32'h7777_8888, 32'hBBBB_CCCC, 32'hFFFF_0000};
    logic [3:0]  wrap_exp[3] = '{4'hE, 4'hF, 4'h0};

    initial begin
        reset_n = 1'b0; enable = 1'b0; reset_op = 1'b0; n_samples = '0;
        in_valid = 1'b0; in_data = '0; up_ready = 1'b0; down_ready = 1'b0;
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_up_valid", up_valid, 0);
        check("rst_down_valid", down_valid, 0);
        check("rst_count", sample_count, 0);
        check("rst_final", finalizacion, 0);
        check("rst_result_up", result_up, 0);

        // four back-to-back samples, limit 4
        reset_n = 1'b1; enable = 1'b1; n_samples = 4; up_ready = 1'b1; down_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = samples[i];
            #1 check("t1_in_ready", in_ready, 1);
            step();
            check("t1_up_valid", up_valid, 1);
            check("t1_up_data", up_data, up_exp[i]);
            check("t1_down_data", down_data, dn_exp[i]);
        end
        in_valid = 1'b0;
        #1;
        check("t1_drain_in_ready", in_ready, 0);
        check("t1_count", sample_count, 4);
        check("t1_final_early", finalizacion, 0);
        step();
        check("t1_final", finalizacion, 1);
        check("t1_up_valid_done", up_valid, 0);
        check("t1_result_up", result_up, 32'hDDDD_EEEE);
        check("t1_result_down", result_down, 32'hFFFF_0000);
        step();
        check("t1_final_held", finalizacion, 1);

        // up sink stalled, down sink ready
        reset_op = 1'b1; step(); reset_op = 1'b0;
        check("t2_rop_final", finalizacion, 0);
        check("t2_rop_count", sample_count, 0);
        check("t2_rop_result_up", result_up, 32'hDDDD_EEEE);
        n_samples = 0;
        step();
        up_ready = 1'b0; in_valid = 1'b1; in_data = 64'hAAAA_BBBB_CCCC_DDDD;
        #1 check("t2_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        #1;
        check("t2_in_ready_blocked", in_ready, 0);
        check("t2_up_data", up_data, 32'hAAAA_BBBB);
        check("t2_down_data", down_data, 32'hCCCC_DDDD);
        step();
        check("t2_down_valid", down_valid, 0);
        check("t2_result_down", result_down, 32'hCCCC_DDDD);
        check("t2_result_up_old", result_up, 32'hDDDD_EEEE);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_up_stable", up_data, 32'hAAAA_BBBB);
            check("t2_up_valid_held", up_valid, 1);
            check("t2_in_ready_held", in_ready, 0);
        end
        up_ready = 1'b1;
        #1 check("t2_in_ready_draining", in_ready, 1);
        step();
        check("t2_result_up", result_up, 32'hAAAA_BBBB);
        check("t2_up_valid_clear", up_valid, 0);
        check("t2_count", sample_count, 1);

        // unlimited run through counter wrap
        in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF;
        repeat (12) step();
        check("t3_count_pre", sample_count, 4'hD);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_count_wrap", sample_count, wrap_exp[i]);
            check("t3_final", finalizacion, 0);
        end
        in_valid = 1'b0;
        step();

        // operation clear while draining with the up half pending
        reset_op = 1'b1; step(); reset_op = 1'b0;
        n_samples = 1;
        step();
        up_ready = 1'b0; in_valid = 1'b1; in_data = 64'hFEDC_BA98_7654_3210;
        step();
        in_valid = 1'b0;
        #1 check("t4_in_ready_drain", in_ready, 0);
        step();
        check("t4_result_down", result_down, 32'h7654_3210);
        check("t4_up_pending", up_valid, 1);
        check("t4_not_final", finalizacion, 0);
        reset_op = 1'b1; step(); reset_op = 1'b0;
        #1;
        check("t4_up_valid", up_valid, 0);
        check("t4_down_valid", down_valid, 0);
        check("t4_count", sample_count, 0);
        check("t4_in_ready", in_ready, 0);
        check("t4_result_up_held", result_up, 32'h0123_4567);
        check("t4_result_down_held", result_down, 32'h7654_3210);

        // enable dropped with a sample pending
        n_samples = 0; up_ready = 1'b1; down_ready = 1'b1;
        step();
        in_valid = 1'b1; in_data = 64'h1357_9BDF_2468_ACE0;
        step();
        enable = 1'b0; up_ready = 1'b0; down_ready = 1'b0; in_data = 64'h0F0F_0F0F_F0F0_F0F0;
        #1 check("t5_in_ready_stalled", in_ready, 0);
        step();
        check("t5_up_pending", up_valid, 1);
        check("t5_up_data", up_data, 32'h1357_9BDF);
        up_ready = 1'b1; down_ready = 1'b1;
        #1 check("t5_in_ready_idle", in_ready, 0);
        step();
        check("t5_up_drained", up_valid, 0);
        check("t5_result_up", result_up, 32'h1357_9BDF);
        check("t5_result_down", result_down, 32'h2468_ACE0);
        check("t5_count_held", sample_count, 1);
        enable = 1'b1;
        step();
        #1 check("t5_in_ready_resume", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("t5_count_resume", sample_count, 2);
        check("t5_up_data_z", up_data, 32'h0F0F_0F0F);

`ifdef FIFO64_SPLIT_STALL_WATCHDOG_EN
        step();
        up_ready = 1'b0; down_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        check("wd_err_before", stall_err, 0);
        step();
        check("wd_err_set", stall_err, 1);
        up_ready = 1'b1; down_ready = 1'b1;
        step();
        check("wd_err_sticky", stall_err, 1);
        reset_op = 1'b1; step(); reset_op = 1'b0;
        check("wd_err_cleared", stall_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
